// File: rtl/dmem_port_arbiter.sv
// ============================================================================
// dmem_port_arbiter: shares the DataMemory port between the CPU MEM stage and
// an auxiliary word requester; CPU-priority with a starvation-forced AUX burst.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_port_arbiter #(
  parameter int         MAX_WAIT  = 4,
  parameter int         AUX_BURST = 2,
  parameter logic [1:0] WORD_CODE = 2'b01
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  cpu_mem_write,
  input  logic [1:0]  cpu_mem_read,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [31:0] aux_addr,
  input  logic [31:0] aux_wdata,
  output logic        aux_gnt,
  output logic        aux_rvalid,
  output logic [31:0] aux_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_write,
  output logic [1:0]  mem_read,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] MAX_WAIT_C  = 8'(MAX_WAIT);
  localparam logic [7:0] AUX_BURST_C = 8'(AUX_BURST);
  localparam logic       BURST_EN_C  = (AUX_BURST > 1);

  typedef enum logic [0:0] {
    ST_CPU       = 1'b0,
    ST_AUX_BURST = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  aux_wait_q, aux_wait_d;
  logic [7:0]  burst_cnt_q, burst_cnt_d;
  logic        aux_rvalid_q, aux_rvalid_d;
  logic [31:0] aux_rdata_q, aux_rdata_d;

  logic        cpu_req;
  logic        wait_hit;
  logic        gnt_raw;

  always_comb begin
    cpu_req     = (|cpu_mem_write) | (|cpu_mem_read);
    wait_hit    = (aux_wait_q == MAX_WAIT_C);
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    gnt_raw     = 1'b0;

    case (state_q)
      ST_CPU: begin
        gnt_raw = aux_req & (~cpu_req | wait_hit);
        if (aux_req & cpu_req & wait_hit & BURST_EN_C) begin
          state_d     = ST_AUX_BURST;
          burst_cnt_d = 8'd1;
        end
      end
      ST_AUX_BURST: begin
        if (aux_req) begin
          gnt_raw     = 1'b1;
          burst_cnt_d = burst_cnt_q + 8'd1;
          if (burst_cnt_q + 8'd1 == AUX_BURST_C) begin
            state_d     = ST_CPU;
            burst_cnt_d = 8'd0;
          end
        end else begin
          state_d     = ST_CPU;
          burst_cnt_d = 8'd0;
        end
      end
      default: begin
        state_d     = ST_CPU;
        burst_cnt_d = 8'd0;
      end
    endcase

    // Reset is used combinationally so the port goes quiet the moment it asserts.
    aux_gnt   = Reset & gnt_raw;
    cpu_stall = cpu_req & aux_gnt;

    if (aux_gnt | ~aux_req) begin
      aux_wait_d = 8'd0;
    end else if (!wait_hit) begin
      aux_wait_d = aux_wait_q + 8'd1;
    end else begin
      aux_wait_d = aux_wait_q;
    end

    if (aux_gnt) begin
      mem_addr  = aux_addr;
      mem_wdata = aux_wdata;
      mem_write = aux_we ? WORD_CODE : 2'b00;
      mem_read  = aux_we ? 2'b00 : WORD_CODE;
    end else begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_write = Reset ? cpu_mem_write : 2'b00;
      mem_read  = Reset ? cpu_mem_read  : 2'b00;
    end

    cpu_rdata    = mem_rdata;
    aux_rvalid_d = aux_gnt & ~aux_we;
    aux_rdata_d  = (aux_gnt & ~aux_we) ? mem_rdata : aux_rdata_q;
    aux_rvalid   = aux_rvalid_q;
    aux_rdata    = aux_rdata_q;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_CPU;
      aux_wait_q   <= 8'd0;
      burst_cnt_q  <= 8'd0;
      aux_rvalid_q <= 1'b0;
      aux_rdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      aux_wait_q   <= aux_wait_d;
      burst_cnt_q  <= burst_cnt_d;
      aux_rvalid_q <= aux_rvalid_d;
      aux_rdata_q  <= aux_rdata_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// ============================================================================
// tb_dmem_port_arbiter: table-driven directed check of dmem_port_arbiter with
// a small behavioural DataMemory. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dmem_port_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [1:0]  cpu_mem_write = 2'b00;
  logic [1:0]  cpu_mem_read = 2'b00;
  logic [31:0] cpu_addr = 32'd0;
  logic [31:0] cpu_wdata = 32'd0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        aux_req = 1'b0;
  logic        aux_we = 1'b0;
  logic [31:0] aux_addr = 32'd0;
  logic [31:0] aux_wdata = 32'd0;
  logic        aux_gnt;
  logic        aux_rvalid;
  logic [31:0] aux_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_write;
  logic [1:0]  mem_read;
  logic [31:0] mem_rdata;

  logic [31:0] mem [16];
  assign mem_rdata = mem[mem_addr[5:2]];

  always #5 Clk = ~Clk;

  dmem_port_arbiter #(.MAX_WAIT(4), .AUX_BURST(2), .WORD_CODE(2'b01)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_mem_write(cpu_mem_write), .cpu_mem_read(cpu_mem_read),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        rst_n;
    logic [1:0]  cmw, cmr;
    logic [31:0] ca, cwd;
    logic        areq, awe;
    logic [31:0] aa, awd;
    logic        e_gnt, e_stall, e_rv;
    logic [1:0]  e_mw, e_mr;
    logic [31:0] e_addr, e_wdata;
    logic        chk_ard;
    logic [31:0] e_ard;
    logic        chk_crd;
    logic [31:0] e_crd;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cur   = 0;

  // Expected port drive follows the hand-specified owner of each cycle.
  function automatic void addv(input logic r, input logic [1:0] cmw, input logic [1:0] cmr,
                               input logic [31:0] ca, input logic [31:0] cwd,
                               input logic areq, input logic awe, input logic [31:0] aa,
                               input logic [31:0] awd, input logic g, input logic st,
                               input logic rv, input logic chk_ard, input logic [31:0] e_ard,
                               input logic chk_crd, input logic [31:0] e_crd);
    vec_t v;
    v.rst_n = r; v.cmw = cmw; v.cmr = cmr; v.ca = ca; v.cwd = cwd;
    v.areq = areq; v.awe = awe; v.aa = aa; v.awd = awd;
    v.e_gnt = g; v.e_stall = st; v.e_rv = rv;
    v.chk_ard = chk_ard; v.e_ard = e_ard; v.chk_crd = chk_crd; v.e_crd = e_crd;
    if (!r) begin
      v.e_mw = 2'b00; v.e_mr = 2'b00; v.e_addr = ca; v.e_wdata = cwd;
    end else if (g) begin
      v.e_mw = awe ? 2'b01 : 2'b00; v.e_mr = awe ? 2'b00 : 2'b01;
      v.e_addr = aa; v.e_wdata = awd;
    end else begin
      v.e_mw = cmw; v.e_mr = cmr; v.e_addr = ca; v.e_wdata = cwd;
    end
    vq.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (vector %0d): got %h, expected %h", nm, cur, act, exp);
    end
  endtask

  // CPU load of 0x04 contending with an AUX read of 0x10.
  function automatic void both_rd(input logic g, input logic rv, input logic chk_ard,
                                  input logic [31:0] e_ard);
    addv(1, 2'b00, 2'b01, 32'h4, 0, 1, 0, 32'h10, 0, g, g, rv, chk_ard, e_ard, 0, 0);
  endfunction

  function automatic void idle(input logic rv);
    addv(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, rv, 0, 0, 0, 0);
  endfunction

  logic        wr_en;
  logic [3:0]  wr_idx;
  logic [31:0] wr_dat;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEADBEEF;

    // Reset gating, then release with a CPU store passing through.
    addv(0, 2'b01, 2'b00, 32'h4, 32'hA5, 1, 0, 32'h10, 0, 0, 0, 0, 1, 32'h0, 0, 0);
    addv(1, 2'b01, 2'b00, 32'h4, 32'hA5, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0);
    addv(1, 2'b00, 2'b01, 32'h4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA5);
    // Opportunistic AUX read, response one cycle later, then held.
    addv(1, 2'b00, 2'b00, 0, 0, 1, 0, 32'h10, 0, 1, 0, 0, 0, 0, 0, 0);
    addv(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF, 0, 0);
    addv(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0);
    // Sustained contention: forced pairs at 4,5 and 10,11.
    both_rd(0, 0, 0, 0);
    vq[$].chk_crd = 1; vq[$].e_crd = 32'hA5;
    for (int c = 1; c < 12; c++)
      both_rd(c == 4 || c == 5 || c == 10 || c == 11, c == 5 || c == 6 || c == 11,
              c == 5, 32'hDEADBEEF);
    idle(1);
    // AUX drops after the first forced grant: burst abandoned, wait restarts.
    for (int c = 0; c < 5; c++) both_rd(c == 4, 0, 0, 0);
    addv(1, 2'b00, 2'b01, 32'h4, 0, 0, 0, 32'h10, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int c = 6; c < 12; c++) both_rd(c >= 10, c == 11, 0, 0);
    idle(1);
    // Forced AUX write under contention, then CPU readback.
    for (int c = 0; c < 5; c++)
      addv(1, 2'b00, 2'b01, 32'h4, 0, 1, 1, 32'h20, 32'h12345678, c == 4, c == 4, 0, 0, 0, 0, 0);
    addv(1, 2'b00, 2'b01, 32'h20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678);
    idle(0);
    // Reset mid-burst: everything cleared, next forced grant 4 cycles after release.
    for (int c = 0; c < 5; c++) both_rd(c == 4, 0, 0, 0);
    addv(0, 2'b00, 2'b01, 32'h4, 0, 1, 0, 32'h10, 0, 0, 0, 0, 1, 32'h0, 0, 0);
    for (int c = 0; c < 6; c++) both_rd(c >= 4, c == 5, 0, 0);
    idle(1);

    for (int i = 0; i < vq.size(); i++) begin
      cur = i;
      @(negedge Clk);
      Reset         = vq[i].rst_n;
      cpu_mem_write = vq[i].cmw;   cpu_mem_read = vq[i].cmr;
      cpu_addr      = vq[i].ca;    cpu_wdata    = vq[i].cwd;
      aux_req       = vq[i].areq;  aux_we       = vq[i].awe;
      aux_addr      = vq[i].aa;    aux_wdata    = vq[i].awd;
      #1;
      chk("aux_gnt",    {31'd0, aux_gnt},    {31'd0, vq[i].e_gnt});
      chk("cpu_stall",  {31'd0, cpu_stall},  {31'd0, vq[i].e_stall});
      chk("aux_rvalid", {31'd0, aux_rvalid}, {31'd0, vq[i].e_rv});
      chk("mem_write",  {30'd0, mem_write},  {30'd0, vq[i].e_mw});
      chk("mem_read",   {30'd0, mem_read},   {30'd0, vq[i].e_mr});
      chk("mem_addr",   mem_addr,  vq[i].e_addr);
      chk("mem_wdata",  mem_wdata, vq[i].e_wdata);
      if (vq[i].chk_ard) chk("aux_rdata", aux_rdata, vq[i].e_ard);
      if (vq[i].chk_crd) chk("cpu_rdata", cpu_rdata, vq[i].e_crd);
      wr_en  = (mem_write != 2'b00);
      wr_idx = mem_addr[5:2];
      wr_dat = mem_wdata;
      @(posedge Clk);
      if (wr_en) mem[wr_idx] = wr_dat;
    end

    // Reset asserted in the middle of a forced grant cycle must drop it at once.
    cur = -1;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      Reset = 1'b1; cpu_mem_write = 2'b00; cpu_mem_read = 2'b01; cpu_addr = 32'h4;
      aux_req = 1'b1; aux_we = 1'b0; aux_addr = 32'h10;
    end
    #1;
    chk("forced_gnt_before_reset", {31'd0, aux_gnt}, 32'd1);
    Reset = 1'b0;
    #1;
    chk("gnt_async_reset",   {31'd0, aux_gnt},   32'd0);
    chk("stall_async_reset", {31'd0, cpu_stall}, 32'd0);
    chk("mrd_async_reset",   {30'd0, mem_read},  32'd0);
    @(negedge Clk);
    Reset = 1'b1; aux_req = 1'b0; cpu_mem_read = 2'b00;
    @(negedge Clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
